seven_seg_scan_ctrl: RTL and testbench

Scan controller for an 8-digit multiplexed seven-segment display. It holds a double-buffered set of per-digit segment patterns and steps through the digits with a programmable dwell time. Each digit slot starts with a ghost-suppression blanking gap, and a PWM brightness window follows the gap. It sits between the register/host logic that writes digit patterns and the board-level segment and digit-select pins.

---
 rtl/seven_seg_pkg.sv | 16 +
 rtl/seven_seg_dbuf.sv | 40 ++++
 rtl/seven_seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam int unsigned DIGIT_IDX_W = 3;
  localparam int unsigned SEG_W       = 8;

  localparam logic [SEG_W-1:0] SEG_OFF  = 8'h00;
  localparam logic [7:0]       SEL_NONE = 8'hFF;

endpackage

// File: rtl/seven_seg_dbuf.sv
// Shadow/active digit pattern buffers: host writes land in shadow, commit copies
// the whole shadow set into active, and the scan reads active by digit index.
module seven_seg_dbuf
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DIGIT_IDX_W-1:0] wr_digit,
  input  logic [SEG_W-1:0]       wr_data,
  input  logic                   copy,
  input  logic [DIGIT_IDX_W-1:0] rd_idx,
  output logic [SEG_W-1:0]       rd_data_c
);

  logic [SEG_W-1:0] shadow [DIGITS];
  logic [SEG_W-1:0] active [DIGITS];

  // Copy uses the pre-write shadow; the write port is closed while a copy is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        shadow[i] <= SEG_OFF;
        active[i] <= SEG_OFF;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_digit] <= wr_data;
      end
      if (copy) begin
        active <= shadow;
      end
    end
  end

  assign rd_data_c = active[rd_idx];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit slot of blanking gap
// followed by a brightness-scaled on window, with frame-aligned buffer commits.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [BRIGHT_W-1:0]    brightness,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DIGIT_IDX_W-1:0] wr_digit,
  input  logic [SEG_W-1:0]       wr_data,
  input  logic                   commit,
  output logic                   commit_done,
  output logic [SEG_W-1:0]       seg,
  output logic [DIGITS-1:0]      seg_sel,
  output logic                   frame_start
);

  localparam int unsigned PHASE_W = $clog2(DWELL_CYCLES);
  localparam int unsigned WIN_W   = PHASE_W + 1;
  localparam int unsigned STEP    = (DWELL_CYCLES - BLANK_CYCLES) / ((1 << BRIGHT_W) - 1);

  state_t                 state, state_n;
  logic [PHASE_W-1:0]     phase, phase_n;
  logic [DIGIT_IDX_W-1:0] idx, idx_n;
  logic [BRIGHT_W-1:0]    bright_q;
  logic                   pending, pending_n;
  logic                   boundary_c, copy_c, frame_c, lit_c;
  logic [WIN_W-1:0]       win_end_c;
  logic [DIGITS-1:0]      sel_c;
  logic [SEG_W-1:0]       rd_data_c;

  seven_seg_dbuf #(
    .DIGITS (DIGITS)
  ) u_dbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_valid & wr_ready),
    .wr_digit  (wr_digit),
    .wr_data   (wr_data),
    .copy      (copy_c),
    .rd_idx    (idx),
    .rd_data_c (rd_data_c)
  );

  // Next-state, frame-boundary and lit-window decode.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    idx_n      = idx;
    frame_c    = 1'b0;
    boundary_c = 1'b0;
    unique case (state)
      IDLE: begin
        phase_n    = '0;
        idx_n      = '0;
        boundary_c = 1'b1;
        if (enable) begin
          state_n = BLANK;
          frame_c = 1'b1;
        end
      end
      BLANK: begin
        phase_n = phase + PHASE_W'(1);
        if (phase == PHASE_W'(BLANK_CYCLES - 1)) begin
          state_n = ON;
        end
      end
      ON: begin
        if (phase == PHASE_W'(DWELL_CYCLES - 1)) begin
          phase_n = '0;
          state_n = BLANK;
          if (idx == DIGIT_IDX_W'(DIGITS - 1)) begin
            idx_n      = '0;
            boundary_c = 1'b1;
            frame_c    = 1'b1;
          end else begin
            idx_n = idx + DIGIT_IDX_W'(1);
          end
        end else begin
          phase_n = phase + PHASE_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (!enable) begin
      state_n = IDLE;
      phase_n = '0;
      idx_n   = '0;
      frame_c = 1'b0;
    end

    copy_c = pending && boundary_c;
    if (copy_c) begin
      pending_n = 1'b0;
    end else if (commit) begin
      pending_n = 1'b1;
    end else begin
      pending_n = pending;
    end

    win_end_c = WIN_W'(BLANK_CYCLES) + WIN_W'(bright_q) * WIN_W'(STEP);
    lit_c     = enable && (state == ON) && ({1'b0, phase} < win_end_c);
    sel_c     = ~(DIGITS'(1) << idx);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= '0;
      idx         <= '0;
      bright_q    <= '0;
      pending     <= 1'b0;
      wr_ready    <= 1'b1;
      commit_done <= 1'b0;
      frame_start <= 1'b0;
      seg         <= SEG_OFF;
      seg_sel     <= '1;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      idx         <= idx_n;
      pending     <= pending_n;
      wr_ready    <= !pending_n;
      commit_done <= copy_c;
      frame_start <= frame_c;
      if ((state == BLANK) && (phase == '0)) begin
        bright_q <= brightness;
      end
      seg     <= lit_c ? rd_data_c : SEG_OFF;
      seg_sel <= lit_c ? sel_c : '1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with a short slot geometry
// (16-cycle slots, 2-cycle blanking, 2-bit brightness, STEP = 4).
module tb_seven_seg_scan_ctrl;
  import seven_seg_pkg::*;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned DWELL  = 16;
  localparam int unsigned BLANKC = 2;
  localparam int unsigned BW     = 2;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [BW-1:0]     brightness;
  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_digit;
  logic [7:0]        wr_data;
  logic              commit;
  logic              commit_done;
  logic [7:0]        seg;
  logic [DIGITS-1:0] seg_sel;
  logic              frame_start;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
    int         len;
    int         off;
  } run_t;

  run_t run_q[$];
  int   fs_q[$];
  int   cd_q[$];

  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   last_fs = 0;
  logic in_run  = 1'b0;
  logic run_ok  = 1'b1;
  run_t cur;
  run_t exp_r;

  seven_seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANKC),
    .BRIGHT_W     (BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .brightness  (brightness),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_digit    (wr_digit),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_done (commit_done),
    .seg         (seg),
    .seg_sel     (seg_sel),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [7:0] sel, input logic [7:0] sg, input int len, input int off);
    run_t r;
    r.sel = sel;
    r.seg = sg;
    r.len = len;
    r.off = off;
    run_q.push_back(r);
  endtask

  // One frame of runs: digit d lit from offset d*16+3 (blank gap plus output register).
  task automatic push_frame(input int len, input logic [7:0] seg5);
    logic [7:0] s;
    logic [7:0] v;
    for (int d = 0; d < 8; d++) begin
      s = 8'h01 << d;
      v = (d == 5) ? seg5 : 8'h10 + 8'(d);
      push_run(~s, v, len, d * 16 + 3);
    end
  endtask

  // Monitor: frame_start / commit_done event timing and lit-run shape.
  always @(negedge clk) begin
    if (frame_start) begin
      if (fs_q.size() == 0) chk("frame_start_unexpected", 32'(frame_start), 32'd0);
      else chk("frame_start_cycle", cyc, fs_q.pop_front());
      last_fs = cyc;
    end
    if (commit_done) begin
      if (cd_q.size() == 0) chk("commit_done_unexpected", 32'(commit_done), 32'd0);
      else chk("commit_done_cycle", cyc, cd_q.pop_front());
    end
    if (seg_sel !== SEL_NONE) begin
      if (!in_run) begin
        in_run  = 1'b1;
        run_ok  = 1'b1;
        cur.sel = seg_sel;
        cur.seg = seg;
        cur.len = 0;
        cur.off = cyc - last_fs;
      end else if (seg_sel !== cur.sel || seg !== cur.seg) begin
        run_ok = 1'b0;
      end
      cur.len = cur.len + 1;
    end else begin
      chk("dark_seg", 32'(seg), 32'(SEG_OFF));
      if (in_run) begin
        in_run = 1'b0;
        checks++;
        if (run_q.size() == 0) begin
          errors++;
          $display("FAIL lit_run_unexpected: got sel=%h seg=%h len=%0d off=%0d expected no lit digit",
                   cur.sel, cur.seg, cur.len, cur.off);
        end else begin
          exp_r = run_q.pop_front();
          if (!run_ok || cur !== exp_r) begin
            errors++;
            $display("FAIL lit_run: got sel=%h seg=%h len=%0d off=%0d stable=%0d expected sel=%h seg=%h len=%0d off=%0d",
                     cur.sel, cur.seg, cur.len, cur.off, run_ok, exp_r.sel, exp_r.seg, exp_r.len, exp_r.off);
          end
        end
      end
    end
  end

  initial begin
    int e;
    rst_n      = 1'b1;
    enable     = 1'b0;
    brightness = '0;
    wr_valid   = 1'b0;
    wr_digit   = '0;
    wr_data    = '0;
    commit     = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_seg_sel", 32'(seg_sel), 32'hFF);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_commit_done", 32'(commit_done), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Full brightness: load 8'h10+d, commit in IDLE, scan two frames.
    for (int d = 0; d < 8; d++) begin
      wr_valid = 1'b1;
      wr_digit = 3'(d);
      wr_data  = 8'h10 + 8'(d);
      tick(1);
    end
    wr_valid = 1'b0;
    commit   = 1'b1;
    cd_q.push_back(cyc + 2);
    tick(1);
    commit = 1'b0;
    chk("wr_ready_pending_idle", 32'(wr_ready), 32'd0);
    tick(1);
    chk("wr_ready_after_copy", 32'(wr_ready), 32'd1);
    e = cyc;
    enable     = 1'b1;
    brightness = 2'd3;
    fs_q.push_back(e + 1);
    fs_q.push_back(e + 129);
    push_frame(12, 8'h15);
    push_frame(12, 8'h15);
    tick(256);
    enable = 1'b0;
    tick(3);

    // Brightness 1 for one frame, then 0 for two frames.
    e = cyc;
    enable     = 1'b1;
    brightness = 2'd1;
    fs_q.push_back(e + 1);
    fs_q.push_back(e + 129);
    fs_q.push_back(e + 257);
    push_frame(4, 8'h15);
    tick(128);
    brightness = 2'd0;
    tick(256);
    enable = 1'b0;
    tick(3);

    // Mid-frame write+commit during digit 3.
    e = cyc;
    enable     = 1'b1;
    brightness = 2'd3;
    fs_q.push_back(e + 1);
    fs_q.push_back(e + 129);
    cd_q.push_back(e + 129);
    push_frame(12, 8'h15);
    push_frame(12, 8'hAA);
    tick(51);
    wr_valid = 1'b1;
    wr_digit = 3'd5;
    wr_data  = 8'hAA;
    commit   = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    commit   = 1'b0;
    chk("wr_ready_pending_start", 32'(wr_ready), 32'd0);
    tick(76);
    chk("wr_ready_pending_end", 32'(wr_ready), 32'd0);
    tick(1);
    chk("wr_ready_at_boundary", 32'(wr_ready), 32'd1);
    tick(127);
    enable = 1'b0;
    tick(3);

    // Brightness 3->1 inside slot 0, then disable inside digit 4's window.
    e = cyc;
    enable     = 1'b1;
    brightness = 2'd3;
    fs_q.push_back(e + 1);
    push_run(8'hFE, 8'h10, 12, 3);
    push_run(8'hFD, 8'h11, 4, 19);
    push_run(8'hFB, 8'h12, 4, 35);
    push_run(8'hF7, 8'h13, 4, 51);
    push_run(8'hEF, 8'h14, 2, 67);
    tick(6);
    brightness = 2'd1;
    tick(63);
    enable = 1'b0;
    tick(5);

    // Re-enable restarts at digit 0; drop enable again one cycle into digit 1.
    e = cyc;
    enable     = 1'b1;
    brightness = 2'd3;
    fs_q.push_back(e + 1);
    push_run(8'hFE, 8'h10, 12, 3);
    push_run(8'hFD, 8'h11, 1, 19);
    tick(20);
    enable = 1'b0;
    tick(3);

    // Async reset while lit, with a commit pending.
    e = cyc;
    enable = 1'b1;
    fs_q.push_back(e + 1);
    push_run(8'hFE, 8'h10, 6, 3);
    tick(3);
    wr_valid = 1'b1;
    wr_digit = 3'd0;
    wr_data  = 8'h55;
    commit   = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    commit   = 1'b0;
    chk("wr_ready_pending_prerst", 32'(wr_ready), 32'd0);
    tick(6);
    chk("lit_before_reset", 32'(seg_sel), 32'hFE);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_seg_sel", 32'(seg_sel), 32'hFF);
    chk("async_rst_seg", 32'(seg), 32'h00);
    chk("async_rst_wr_ready", 32'(wr_ready), 32'd1);
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_seg_sel", 32'(seg_sel), 32'hFF);

    // Active buffer cleared by reset: digit 0 lights with a blank pattern.
    e = cyc;
    enable = 1'b1;
    fs_q.push_back(e + 1);
    push_run(8'hFE, 8'h00, 7, 3);
    tick(10);
    enable = 1'b0;
    tick(20);

    chk("runs_outstanding", run_q.size(), 32'd0);
    chk("frame_starts_outstanding", fs_q.size(), 32'd0);
    chk("commit_dones_outstanding", cd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
